mem_stage: RTL and testbench

- Memory-access pipeline stage between the EX stage and wb_stage.
- Holds one instruction and waits for the data-SRAM response when that instruction is a load.
- Aligns and extends the load data, then forwards the result on ms_to_ws_bus in the 75-bit layout wb_stage consumes.
- Discards stale SRAM responses after a WB-stage exception or ERET flush.

---
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one entry, waits for the data-SRAM load response,
// aligns/extends load data, and drops responses orphaned by a WB flush.
module mem_stage #(
    parameter int DISCARD_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [78:0] es_to_ms_bus,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [74:0] ms_to_ws_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        es_flush_req_outstanding,
    input  logic        WS_EX,
    input  logic        ERET,
    output logic        MS_EX,
    output logic [4:0]  MEM_dest,
    output logic [31:0] MEM_dest_data,
    output logic        ms_load_pending
);
    localparam logic [DISCARD_W+1:0] DISC_MAX = {2'b00, {DISCARD_W{1'b1}}};

    logic                 ms_valid_q, ms_valid_d;
    logic [78:0]          bus_q, bus_d;
    logic [31:0]          rbuf_q, rbuf_d;
    logic                 rbuf_valid_q, rbuf_valid_d;
    logic [DISCARD_W-1:0] discard_q, discard_d;

    logic [2:0]  ex_code, ld_type;
    logic        eret, bd, mem_re, gr_we, load, flush;
    logic [4:0]  dest;
    logic [31:0] alu_result, pc, ld_data, final_result;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        data_ok_live, ms_ready_go;
    logic [1:0]  disc_inc;
    logic        disc_dec;
    logic [DISCARD_W+1:0] disc_sum;

    assign ex_code    = bus_q[78:76];
    assign eret       = bus_q[75];
    assign bd         = bus_q[74];
    assign mem_re     = bus_q[73];
    assign ld_type    = bus_q[72:70];
    assign gr_we      = bus_q[69];
    assign dest       = bus_q[68:64];
    assign alu_result = bus_q[63:32];
    assign pc         = bus_q[31:0];

    assign load  = mem_re & (ex_code == 3'd0) & ~eret;
    assign flush = WS_EX | ERET;

    // A response only belongs to this entry once all orphaned ones are drained.
    assign data_ok_live   = data_sram_data_ok & (discard_q == '0);
    assign ms_ready_go    = ~load | rbuf_valid_q | data_ok_live;
    assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;

    assign ld_data = rbuf_valid_q ? rbuf_q : data_sram_rdata;

    always_comb begin
        ld_byte = ld_data[7:0];
        case (alu_result[1:0])
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            2'd3:    ld_byte = ld_data[31:24];
            default: ld_byte = ld_data[7:0];
        endcase
        ld_half = alu_result[1] ? ld_data[31:16] : ld_data[15:0];
        case (ld_type)
            3'd1:    final_result = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    final_result = {24'd0, ld_byte};
            3'd3:    final_result = {{16{ld_half[15]}}, ld_half};
            3'd4:    final_result = {16'd0, ld_half};
            default: final_result = ld_data;
        endcase
        if (!load) final_result = alu_result;
    end

    assign ms_to_ws_bus    = {ex_code, eret, bd, gr_we, dest, final_result, pc};
    assign MS_EX           = ms_valid_q & ((ex_code != 3'd0) | eret);
    assign MEM_dest        = dest & {5{ms_valid_q & gr_we}};
    assign MEM_dest_data   = final_result;
    assign ms_load_pending = ms_valid_q & load & ~ms_ready_go;

    always_comb begin
        ms_valid_d   = ms_valid_q;
        bus_d        = bus_q;
        rbuf_d       = rbuf_q;
        rbuf_valid_d = rbuf_valid_q;
        disc_inc     = 2'd0;
        disc_dec     = data_sram_data_ok & (discard_q != '0);

        if (flush) begin
            ms_valid_d   = 1'b0;
            rbuf_valid_d = 1'b0;
            disc_inc     = {1'b0, ms_valid_q & load & ~rbuf_valid_q & ~data_ok_live}
                         + {1'b0, es_flush_req_outstanding};
        end else begin
            if (ms_allowin) ms_valid_d = es_to_ms_valid;
            if (es_to_ms_valid && ms_allowin) bus_d = es_to_ms_bus;
            if (ms_to_ws_valid && ws_allowin) begin
                rbuf_valid_d = 1'b0;
            end else if (data_ok_live && ms_valid_q && load && !rbuf_valid_q) begin
                rbuf_valid_d = 1'b1;
                rbuf_d       = data_sram_rdata;
            end
        end

        disc_sum  = {2'b00, discard_q} + {{DISCARD_W{1'b0}}, disc_inc}
                  - {{(DISCARD_W+1){1'b0}}, disc_dec};
        discard_d = (disc_sum > DISC_MAX) ? DISC_MAX[DISCARD_W-1:0]
                                          : disc_sum[DISCARD_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            bus_q        <= '0;
            rbuf_q       <= '0;
            rbuf_valid_q <= 1'b0;
            discard_q    <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            bus_q        <= bus_d;
            rbuf_q       <= rbuf_d;
            rbuf_valid_q <= rbuf_valid_d;
            discard_q    <= discard_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [78:0] es_to_ms_bus;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [74:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        es_flush_req_outstanding;
  logic        WS_EX, ERET;
  logic        MS_EX;
  logic [4:0]  MEM_dest;
  logic [31:0] MEM_dest_data;
  logic        ms_load_pending;

  int n_asrt = 0;
  int n_fail = 0;

  localparam logic [31:0] PC      = 32'hBFC0_0100;
  localparam logic [2:0]  EX_SYS  = 3'd2;

  mem_stage #(.DISCARD_W(2)) dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .es_flush_req_outstanding(es_flush_req_outstanding),
    .WS_EX(WS_EX), .ERET(ERET), .MS_EX(MS_EX), .MEM_dest(MEM_dest),
    .MEM_dest_data(MEM_dest_data), .ms_load_pending(ms_load_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [78:0] mk(input logic [2:0] ex, input logic er,
                                     input logic mre, input logic [2:0] ldt,
                                     input logic gwe, input logic [4:0] d,
                                     input logic [31:0] a);
    return {ex, er, 1'b0, mre, ldt, gwe, d, a, PC};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [78:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    tick();
    es_to_ms_valid = 1'b0;
    #1;
  endtask

  logic [2:0]  t_ldt [6] = '{3'd1, 3'd4, 3'd2, 3'd3, 3'd0, 3'd3};
  logic [31:0] t_adr [6] = '{32'h1003, 32'h1002, 32'h1003, 32'h1002, 32'h1000, 32'h1000};
  logic [31:0] t_exp [6] = '{32'hFFFF_FF80, 32'h0000_80AA, 32'h0000_0080,
                             32'hFFFF_80AA, 32'h80AA_55CC, 32'h0000_55CC};

  initial begin
    reset = 1'b1;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    es_flush_req_outstanding = 1'b0; WS_EX = 1'b0; ERET = 1'b0;
    #2;
    chk("rst_valid",   ms_to_ws_valid,  1'b0);
    chk("rst_allowin", ms_allowin,      1'b1);
    chk("rst_dest",    MEM_dest,        5'd0);
    chk("rst_msex",    MS_EX,           1'b0);
    chk("rst_pend",    ms_load_pending, 1'b0);
    #10 reset = 1'b0;
    tick();

    enter(mk(3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 5'd5, 32'h1234));
    chk("alu_valid",  ms_to_ws_valid,       1'b1);
    chk("alu_dest",   ms_to_ws_bus[68:64],  5'd5);
    chk("alu_res",    ms_to_ws_bus[63:32],  32'h1234);
    chk("alu_pc",     ms_to_ws_bus[31:0],   PC);
    chk("alu_fwd",    MEM_dest,             5'd5);
    chk("alu_pend",   ms_load_pending,      1'b0);
    tick();
    chk("alu_drain",  ms_to_ws_valid,       1'b0);

    data_sram_rdata = 32'h80AA_55CC;
    enter(mk(3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 5'd7, 32'h1003));
    for (int i = 0; i < 3; i++) begin
      chk("lb_pend",  ms_load_pending, 1'b1);
      chk("lb_wait",  ms_to_ws_valid,  1'b0);
      if (i < 2) tick();
      else begin data_sram_data_ok = 1'b1; #1; end
    end
    chk("lb_valid",  ms_to_ws_valid,      1'b1);
    chk("lb_res",    ms_to_ws_bus[63:32], 32'hFFFF_FF80);
    chk("lb_nopend", ms_load_pending,     1'b0);
    tick();
    data_sram_data_ok = 1'b0;

    for (int k = 0; k < 6; k++) begin
      enter(mk(3'd0, 1'b0, 1'b1, t_ldt[k], 1'b1, 5'd3, t_adr[k]));
      data_sram_data_ok = 1'b1;
      #1;
      chk("align_valid", ms_to_ws_valid,      1'b1);
      chk("align_res",   ms_to_ws_bus[63:32], t_exp[k]);
      chk("align_fwd",   MEM_dest_data,       t_exp[k]);
      tick();
      data_sram_data_ok = 1'b0;
    end

    enter(mk(3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 5'd4, 32'h2000));
    ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1122_3344;
    #1;
    chk("buf_valid0",  ms_to_ws_valid, 1'b1);
    chk("buf_allowin", ms_allowin,     1'b0);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("buf_valid1", ms_to_ws_valid,      1'b1);
    chk("buf_res1",   ms_to_ws_bus[63:32], 32'h1122_3344);
    tick();
    ws_allowin = 1'b1;
    #1;
    chk("buf_valid2", ms_to_ws_valid,      1'b1);
    chk("buf_res2",   ms_to_ws_bus[63:32], 32'h1122_3344);
    tick();
    chk("buf_drain",  ms_to_ws_valid,      1'b0);

    enter(mk(3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 5'd8, 32'h3000));
    chk("fl_pend", ms_load_pending, 1'b1);
    WS_EX = 1'b1; es_flush_req_outstanding = 1'b1;
    tick();
    WS_EX = 1'b0; es_flush_req_outstanding = 1'b0;
    chk("fl_valid",   ms_to_ws_valid, 1'b0);
    chk("fl_allowin", ms_allowin,     1'b1);
    enter(mk(3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 5'd9, 32'h4000));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA_0001;
    #1;
    chk("drop1_valid", ms_to_ws_valid,  1'b0);
    chk("drop1_pend",  ms_load_pending, 1'b1);
    tick();
    data_sram_rdata = 32'hAAAA_0002;
    #1;
    chk("drop2_valid", ms_to_ws_valid, 1'b0);
    tick();
    data_sram_rdata = 32'h1234_5678;
    #1;
    chk("fl3_valid", ms_to_ws_valid,      1'b1);
    chk("fl3_res",   ms_to_ws_bus[63:32], 32'h1234_5678);
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    chk("fl3_drain", ms_to_ws_valid, 1'b0);

    enter(mk(3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 5'd10, 32'h5000));
    WS_EX = 1'b1; es_flush_req_outstanding = 1'b1;
    tick();
    WS_EX = 1'b0; es_flush_req_outstanding = 1'b0;
    enter(mk(3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 5'd11, 32'h5004));
    chk("ar_pend0", ms_load_pending, 1'b1);
    reset = 1'b1;
    #1;
    chk("ar_valid",   ms_to_ws_valid,  1'b0);
    chk("ar_allowin", ms_allowin,      1'b1);
    chk("ar_pend",    ms_load_pending, 1'b0);
    chk("ar_dest",    MEM_dest,        5'd0);
    #1 reset = 1'b0;
    tick();
    enter(mk(3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 5'd12, 32'h5008));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    #1;
    chk("ar_ld_valid", ms_to_ws_valid,      1'b1);
    chk("ar_ld_res",   ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    tick();
    data_sram_data_ok = 1'b0;

    enter(mk(EX_SYS, 1'b0, 1'b1, 3'd0, 1'b0, 5'd13, 32'h6000));
    chk("sys_valid", ms_to_ws_valid,      1'b1);
    chk("sys_msex",  MS_EX,               1'b1);
    chk("sys_pend",  ms_load_pending,     1'b0);
    chk("sys_code",  ms_to_ws_bus[74:72], EX_SYS);
    chk("sys_res",   ms_to_ws_bus[63:32], 32'h6000);
    chk("sys_dest",  MEM_dest,            5'd0);
    tick();
    enter(mk(3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0));
    chk("eret_msex", MS_EX,            1'b1);
    chk("eret_bit",  ms_to_ws_bus[71], 1'b1);
    tick();
    chk("end_msex",  MS_EX,            1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
